// File: rtl/plane_wave_ramp.sv
// plane_wave_ramp: difficulty ramp controller for the enemy plane count.
// The count rises on every FRAMES_PER_STEP frame ticks and, when KILL_RAMP_EN
// is defined, on every KILLS_PER_STEP kills. It holds while paused, saturates
// at MAX_AMOUNT, freezes on game over and reloads on game start.
// Optional feature macro: KILL_RAMP_EN (kill-based stepping).
module plane_wave_ramp #(
    parameter int unsigned FRAMES_PER_STEP = 600,
    parameter int unsigned KILLS_PER_STEP  = 5,
    parameter int unsigned START_AMOUNT    = 1,
    parameter int unsigned MAX_AMOUNT      = 10
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic       game_start,
    input  logic       game_over,
    input  logic       pause,
    input  logic       kill_pulse,
    output logic [3:0] plane_amount,
    output logic       level_up,
    output logic       maxed,
    output logic [1:0] state
);

    localparam int unsigned FW = $clog2(FRAMES_PER_STEP);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_STEP - 1);
    localparam logic [3:0] AMT_START = 4'(START_AMOUNT);
    localparam logic [3:0] AMT_MAX   = 4'(MAX_AMOUNT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        MAXED = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam state_t RELOAD_STATE = (START_AMOUNT == MAX_AMOUNT) ? MAXED : RUN;

    state_t        state_q, state_d;
    logic [3:0]    amount_q, amount_d;
    logic          level_q, level_d;
    logic [FW-1:0] frame_q;
    logic          time_step, kill_step;
    logic          clear_cnt;   // both step counters return to zero
    logic          advance;     // counting cycle without a step: counters follow their pulses

    assign time_step = frame_tick && (frame_q == FRAME_LAST);

`ifdef KILL_RAMP_EN
    localparam int unsigned KW = $clog2(KILLS_PER_STEP + 1);
    localparam logic [KW-1:0] KILL_LAST = KW'(KILLS_PER_STEP - 1);

    logic [KW-1:0] kill_q;

    assign kill_step = kill_pulse && (kill_q == KILL_LAST);

    // Kill counter: cleared on steps and outside active counting
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            kill_q <= '0;
        else if (clear_cnt)
            kill_q <= '0;
        else if (advance && kill_pulse)
            kill_q <= kill_q + KW'(1);
    end
`else
    logic unused_kill;
    assign unused_kill = kill_pulse;
    assign kill_step   = 1'b0;
`endif

    // State register together with the registered count and level pulse
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            amount_q <= AMT_START;
            level_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            amount_q <= amount_d;
            level_q  <= level_d;
        end
    end

    // Frame counter: cleared on steps and outside active counting
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            frame_q <= '0;
        else if (clear_cnt)
            frame_q <= '0;
        else if (advance && frame_tick)
            frame_q <= frame_q + FW'(1);
    end

    // Next-state logic; game_start outranks game_over, which outranks a step
    always_comb begin
        state_d   = state_q;
        amount_d  = amount_q;
        level_d   = 1'b0;
        clear_cnt = 1'b0;
        advance   = 1'b0;
        if (game_start) begin
            state_d   = RELOAD_STATE;
            amount_d  = AMT_START;
            clear_cnt = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    amount_d  = AMT_START;
                    clear_cnt = 1'b1;
                end
                RUN: begin
                    if (game_over) begin
                        state_d   = OVER;
                        clear_cnt = 1'b1;
                    end else if (!pause) begin
                        if (time_step || kill_step) begin
                            amount_d  = (amount_q < AMT_MAX) ? amount_q + 4'd1 : AMT_MAX;
                            level_d   = 1'b1;
                            clear_cnt = 1'b1;
                            if (amount_q + 4'd1 >= AMT_MAX)
                                state_d = MAXED;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end
                MAXED: begin
                    amount_d  = AMT_MAX;
                    clear_cnt = 1'b1;
                    if (game_over)
                        state_d = OVER;
                end
                OVER: begin
                    clear_cnt = 1'b1;
                end
                default: begin
                    state_d   = IDLE;
                    amount_d  = AMT_START;
                    clear_cnt = 1'b1;
                end
            endcase
        end
    end

    // Outputs come straight from registers
    always_comb begin
        plane_amount = amount_q;
        level_up     = level_q;
        maxed        = (state_q == MAXED);
        state        = state_q;
    end

endmodule
